// File: rtl/lcd_pattern_engine.sv
// Full-screen test-pattern source for the SPI LCD path: CASET/RASET/RAMWR window header, then RGB565 pixels.
// Optional build macro LCD_PATTERN_CHECKER_EN blacks out alternate 16x16 tiles (checkerboard).
module lcd_pattern_engine #(
  parameter int H_RES        = 240,
  parameter int V_RES        = 320,
  parameter int NUM_PATTERNS = 8,
  parameter int DWELL_CYCLES = 150000000
) (
  input  logic       clk_50MHz,
  input  logic       rst_n,
  input  logic       init_done,
  input  logic       wr_done,
  input  logic       pause,
  input  logic       next_req,
  output logic [8:0] data,
  output logic       en_write,
  output logic [2:0] pattern_id,
  output logic       frame_done
);

  typedef enum logic [1:0] {IDLE, WIN, PIX, FEND} state_t;

  localparam logic [11:0] H_LAST     = 12'(H_RES - 1);
  localparam logic [11:0] V_LAST     = 12'(V_RES - 1);
  localparam logic [2:0]  PAT_LAST   = 3'(NUM_PATTERNS - 1);
  localparam int          DW         = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);

  state_t        state, state_nx;
  logic [3:0]    win_cnt;
  logic [11:0]   x_cnt, y_cnt;
  logic          lo_byte;
  logic [DW-1:0] dwell_cnt;
  logic          pending;

  logic          accept, last_pix_byte;
  logic          timer_run, timer_wrap, advance_req;
  logic [8:0]    win_byte;
  logic [15:0]   colour, pixel;

  assign accept        = en_write & wr_done;
  assign last_pix_byte = lo_byte && (x_cnt == H_LAST) && (y_cnt == V_LAST);
  assign timer_run     = (state != IDLE) && !pause;
  assign timer_wrap    = timer_run && (dwell_cnt == DWELL_LAST);
  assign advance_req   = timer_wrap | next_req;

  always_comb begin
    case (win_cnt)
      4'd0:    win_byte = 9'h02A;
      4'd3:    win_byte = {5'b1_0000, H_LAST[11:8]};
      4'd4:    win_byte = {1'b1, H_LAST[7:0]};
      4'd5:    win_byte = 9'h02B;
      4'd8:    win_byte = {5'b1_0000, V_LAST[11:8]};
      4'd9:    win_byte = {1'b1, V_LAST[7:0]};
      4'd10:   win_byte = 9'h02C;
      default: win_byte = 9'h100;
    endcase
  end

  always_comb begin
    case (pattern_id)
      3'd0:    colour = 16'hF800;
      3'd1:    colour = 16'h07E0;
      3'd2:    colour = 16'h001F;
      3'd3:    colour = 16'hFFE0;
      3'd4:    colour = 16'hFFFF;
      3'd5:    colour = 16'h07FF;
      3'd6:    colour = 16'h781F;
      default: colour = 16'hF81F;
    endcase
  end

`ifdef LCD_PATTERN_CHECKER_EN
  assign pixel = (x_cnt[4] ^ y_cnt[4]) ? 16'h0000 : colour;
`else
  assign pixel = colour;
`endif

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    state_nx   = state;
    en_write   = 1'b0;
    data       = 9'h000;
    frame_done = 1'b0;
    case (state)
      IDLE: if (init_done) state_nx = WIN;
      WIN: begin
        en_write = 1'b1;
        data     = win_byte;
        if (accept && win_cnt == 4'd10) state_nx = PIX;
      end
      PIX: begin
        en_write = 1'b1;
        data     = {1'b1, lo_byte ? pixel[7:0] : pixel[15:8]};
        if (accept && last_pix_byte) state_nx = FEND;
      end
      FEND: begin
        frame_done = 1'b1;
        state_nx   = WIN;
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      win_cnt    <= '0;
      x_cnt      <= '0;
      y_cnt      <= '0;
      lo_byte    <= 1'b0;
      dwell_cnt  <= '0;
      pending    <= 1'b0;
      pattern_id <= '0;
    end else begin
      state <= state_nx;

      if (state == WIN && accept)
        win_cnt <= (win_cnt == 4'd10) ? 4'd0 : win_cnt + 4'd1;

      // Raster walk: x wraps at the line end and carries into y, so no divider is needed.
      if (state == PIX && accept) begin
        lo_byte <= ~lo_byte;
        if (lo_byte) begin
          if (x_cnt == H_LAST) begin
            x_cnt <= '0;
            y_cnt <= (y_cnt == V_LAST) ? 12'd0 : y_cnt + 12'd1;
          end else begin
            x_cnt <= x_cnt + 12'd1;
          end
        end
      end

      if (timer_run)
        dwell_cnt <= timer_wrap ? '0 : dwell_cnt + 1'b1;

      // Requests arriving in the frame-end cycle itself belong to the next frame.
      if (state == FEND) begin
        if (pending)
          pattern_id <= (pattern_id == PAT_LAST) ? 3'd0 : pattern_id + 3'd1;
        pending <= advance_req;
      end else if (advance_req) begin
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lcd_pattern_engine.sv
// Self-checking bench for lcd_pattern_engine: four parameterisations compared every cycle against a
// frame-level model, plus hand-computed byte and pattern expectations.
module tb_lcd_pattern_engine;

  localparam int NI    = 4;
  localparam int LOG_N = 1024;
  localparam int FR_N  = 32;
  localparam int CFG_H  [NI] = '{4, 4, 4, 32};
  localparam int CFG_V  [NI] = '{2, 2, 2, 1};
  localparam int CFG_NP [NI] = '{8, 8, 3, 8};
  localparam int CFG_DW [NI] = '{100000, 20, 20, 100000};
  localparam logic [15:0] COLOURS [8] =
    '{16'hF800, 16'h07E0, 16'h001F, 16'hFFE0, 16'hFFFF, 16'h07FF, 16'h781F, 16'hF81F};

  logic clk_50MHz = 1'b0;
  always #10 clk_50MHz = ~clk_50MHz;

  logic [NI-1:0] rst_n_v, init_v, pause_v, next_v, wr_done_v;
  logic          en_v   [NI];
  logic          fd_v   [NI];
  logic [8:0]    data_v [NI];
  logic [2:0]    pid_v  [NI];

  int n_checks = 0;
  int n_errors = 0;

  lcd_pattern_engine #(.H_RES(CFG_H[0]), .V_RES(CFG_V[0]), .NUM_PATTERNS(CFG_NP[0]), .DWELL_CYCLES(CFG_DW[0]))
    u0 (.clk_50MHz(clk_50MHz), .rst_n(rst_n_v[0]), .init_done(init_v[0]), .wr_done(wr_done_v[0]),
        .pause(pause_v[0]), .next_req(next_v[0]), .data(data_v[0]), .en_write(en_v[0]),
        .pattern_id(pid_v[0]), .frame_done(fd_v[0]));
  lcd_pattern_engine #(.H_RES(CFG_H[1]), .V_RES(CFG_V[1]), .NUM_PATTERNS(CFG_NP[1]), .DWELL_CYCLES(CFG_DW[1]))
    u1 (.clk_50MHz(clk_50MHz), .rst_n(rst_n_v[1]), .init_done(init_v[1]), .wr_done(wr_done_v[1]),
        .pause(pause_v[1]), .next_req(next_v[1]), .data(data_v[1]), .en_write(en_v[1]),
        .pattern_id(pid_v[1]), .frame_done(fd_v[1]));
  lcd_pattern_engine #(.H_RES(CFG_H[2]), .V_RES(CFG_V[2]), .NUM_PATTERNS(CFG_NP[2]), .DWELL_CYCLES(CFG_DW[2]))
    u2 (.clk_50MHz(clk_50MHz), .rst_n(rst_n_v[2]), .init_done(init_v[2]), .wr_done(wr_done_v[2]),
        .pause(pause_v[2]), .next_req(next_v[2]), .data(data_v[2]), .en_write(en_v[2]),
        .pattern_id(pid_v[2]), .frame_done(fd_v[2]));
  lcd_pattern_engine #(.H_RES(CFG_H[3]), .V_RES(CFG_V[3]), .NUM_PATTERNS(CFG_NP[3]), .DWELL_CYCLES(CFG_DW[3]))
    u3 (.clk_50MHz(clk_50MHz), .rst_n(rst_n_v[3]), .init_done(init_v[3]), .wr_done(wr_done_v[3]),
        .pause(pause_v[3]), .next_req(next_v[3]), .data(data_v[3]), .en_write(en_v[3]),
        .pattern_id(pid_v[3]), .frame_done(fd_v[3]));

  task automatic check(input string name, input int inst, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL u%0d %s: got %h, expected %h (t=%0t)", inst, name, act, exp, $time);
    end
  endtask

  // Byte k of a frame, derived from the frame layout: header table, then pixels in raster order.
  function automatic logic [8:0] exp_byte(input int inst, input int idx, input int pat);
    int h, v, p, x, y;
    logic [11:0] hl, vl;
    logic [15:0] c;
    logic [8:0]  r;
    h  = CFG_H[inst];
    v  = CFG_V[inst];
    hl = 12'(h - 1);
    vl = 12'(v - 1);
    if (idx < 11) begin
      case (idx)
        0:       r = 9'h02A;
        3:       r = {5'b1_0000, hl[11:8]};
        4:       r = {1'b1, hl[7:0]};
        5:       r = 9'h02B;
        8:       r = {5'b1_0000, vl[11:8]};
        9:       r = {1'b1, vl[7:0]};
        10:      r = 9'h02C;
        default: r = 9'h100;
      endcase
    end else begin
      p = (idx - 11) / 2;
      x = p % h;
      y = p / h;
      c = COLOURS[pat];
`ifdef LCD_PATTERN_CHECKER_EN
      if (((x / 16) + (y / 16)) % 2 == 1) c = 16'h0000;
`endif
      r = ((idx - 11) % 2 == 0) ? {1'b1, c[15:8]} : {1'b1, c[7:0]};
    end
    return r;
  endfunction

  // Link partner: wr_done arrives two cycles after each byte is first offered.
  initial begin
    int age [NI];
    wr_done_v = '0;
    for (int i = 0; i < NI; i++) age[i] = 0;
    forever begin
      @(posedge clk_50MHz);
      #2;
      for (int i = 0; i < NI; i++) begin
        if (!rst_n_v[i] || !en_v[i]) begin
          age[i] = 0;
          wr_done_v[i] = 1'b0;
        end else begin
          if (wr_done_v[i]) age[i] = 0;
          age[i]++;
          wr_done_v[i] = (age[i] == 3);
        end
      end
    end
  end

  // Frame-level model and logs of everything accepted.
  int          m_idx [NI], m_pat [NI], m_dn [NI];
  bit          m_run [NI], m_pend [NI], m_fend [NI];
  logic [8:0]  acc_log [NI][LOG_N];
  int          log_cnt [NI];
  logic [2:0]  fr_pid [NI][FR_N];
  int          fr_cnt [NI];
  bit          cmp_on = 1'b1;

  task automatic cmp_one(input int i);
    logic [15:0] act, exp;
    bit set_now;
    act = {2'b00, en_v[i], fd_v[i], pid_v[i], data_v[i]};
    if (!rst_n_v[i]) begin
      check("reset outputs", i, act, 16'h0000);
      m_run[i] = 0; m_idx[i] = 0; m_pat[i] = 0; m_dn[i] = 0; m_pend[i] = 0; m_fend[i] = 0;
      return;
    end
    if (!m_run[i]) begin
      check("idle outputs", i, act, 16'h0000);
      if (init_v[i]) m_run[i] = 1;
      if (next_v[i]) m_pend[i] = 1;
      return;
    end
    set_now = next_v[i];
    if (!pause_v[i]) begin
      m_dn[i]++;
      if (m_dn[i] == CFG_DW[i]) begin
        m_dn[i] = 0;
        set_now = 1;
      end
    end
    if (m_fend[i]) begin
      exp = {11'b0, 1'b0, 1'b1, 3'(m_pat[i])};
      check("frame end en/done/pid", i, {11'b0, act[13:9]}, exp);
      if (fr_cnt[i] < FR_N) fr_pid[i][fr_cnt[i]] = pid_v[i];
      fr_cnt[i]++;
      if (m_pend[i]) m_pat[i] = (m_pat[i] + 1) % CFG_NP[i];
      m_pend[i] = set_now;
      m_fend[i] = 0;
      m_idx[i]  = 0;
    end else begin
      exp = {2'b00, 1'b1, 1'b0, 3'(m_pat[i]), exp_byte(i, m_idx[i], m_pat[i])};
      check("stream byte", i, act, exp);
      if (wr_done_v[i]) begin
        if (log_cnt[i] < LOG_N) acc_log[i][log_cnt[i]] = data_v[i];
        log_cnt[i]++;
        m_idx[i]++;
        if (m_idx[i] == 11 + 2 * CFG_H[i] * CFG_V[i]) m_fend[i] = 1;
      end
      if (set_now) m_pend[i] = 1;
    end
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      m_run[i] = 0; m_idx[i] = 0; m_pat[i] = 0; m_dn[i] = 0; m_pend[i] = 0; m_fend[i] = 0;
      log_cnt[i] = 0; fr_cnt[i] = 0;
    end
    while (cmp_on) begin
      @(negedge clk_50MHz);
      if (cmp_on)
        for (int i = 0; i < NI; i++) cmp_one(i);
    end
  end

  task automatic wait_bytes(input int i, input int n);
    int t = 0;
    while (log_cnt[i] < n && t < 5000) begin
      @(posedge clk_50MHz);
      t++;
    end
    check("byte count reached", i, 16'(log_cnt[i] >= n), 16'd1);
  endtask

  task automatic wait_frames(input int i, input int n);
    int t = 0;
    while (fr_cnt[i] < n && t < 5000) begin
      @(posedge clk_50MHz);
      t++;
    end
    check("frame count reached", i, 16'(fr_cnt[i] >= n), 16'd1);
  endtask

  task automatic pulse_next(input int i);
    @(posedge clk_50MHz);
    #1 next_v[i] = 1'b1;
    @(posedge clk_50MHz);
    #1 next_v[i] = 1'b0;
  endtask

  initial begin
    logic [8:0] hdr [11];
    logic [8:0] x16_hi, x16_lo;
    int rst_mark;
    hdr = '{9'h02A, 9'h100, 9'h100, 9'h100, 9'h103, 9'h02B, 9'h100, 9'h100, 9'h100, 9'h101, 9'h02C};
    rst_n_v = '0;
    init_v  = '0;
    pause_v = 4'b0100;
    next_v  = '0;
    repeat (3) @(posedge clk_50MHz);
    #1 rst_n_v = '1;
    repeat (3) @(posedge clk_50MHz);
    #1 init_v = '1;

    // u0: one-cycle reset while byte 15 of the second frame is on the bus.
    wait_bytes(0, 27 + 15);
    @(posedge clk_50MHz);
    #1 rst_n_v[0] = 1'b0;
    rst_mark = log_cnt[0];
    @(posedge clk_50MHz);
    #1 rst_n_v[0] = 1'b1;

    // u2 (paused, 3 patterns): three requests in frame 5, then one in each of frames 6 and 7.
    wait_bytes(2, 5 * 27 + 3);
    pulse_next(2);
    wait_bytes(2, 5 * 27 + 10);
    pulse_next(2);
    wait_bytes(2, 5 * 27 + 20);
    pulse_next(2);
    wait_bytes(2, 6 * 27 + 5);
    pulse_next(2);
    wait_bytes(2, 7 * 27 + 5);
    pulse_next(2);

    wait_frames(2, 9);
    wait_frames(1, 3);
    wait_frames(3, 2);
    wait_bytes(0, rst_mark + 2);
    cmp_on = 1'b0;
    @(posedge clk_50MHz);

    for (int k = 0; k < 11; k++) check("first header byte", 0, 16'(acc_log[0][k]), 16'(hdr[k]));
    for (int k = 11; k < 27; k++)
      check("first pixel byte", 0, 16'(acc_log[0][k]), (k % 2 == 1) ? 16'h01F8 : 16'h0100);
    check("first byte after reset", 0, 16'(acc_log[0][rst_mark]), 16'h002A);
    check("second byte after reset", 0, 16'(acc_log[0][rst_mark + 1]), 16'h0100);

    check("frame0 pattern", 1, 16'(fr_pid[1][0]), 16'd0);
    check("frame1 pattern", 1, 16'(fr_pid[1][1]), 16'd1);
    check("frame2 pattern", 1, 16'(fr_pid[1][2]), 16'd2);
    check("frame0 pixel hi", 1, 16'(acc_log[1][11]), 16'h01F8);
    check("frame1 pixel hi", 1, 16'(acc_log[1][38]), 16'h0107);
    check("frame1 pixel lo", 1, 16'(acc_log[1][39]), 16'h01E0);

    for (int f = 0; f < 5; f++) check("paused frame pattern", 2, 16'(fr_pid[2][f]), 16'd0);
    check("frame5 pattern", 2, 16'(fr_pid[2][5]), 16'd0);
    check("frame6 pattern", 2, 16'(fr_pid[2][6]), 16'd1);
    check("frame7 pattern", 2, 16'(fr_pid[2][7]), 16'd2);
    check("frame8 pattern wrap", 2, 16'(fr_pid[2][8]), 16'd0);
    check("frame6 pixel hi", 2, 16'(acc_log[2][173]), 16'h0107);
    check("frame7 pixel hi", 2, 16'(acc_log[2][200]), 16'h0100);
    check("frame7 pixel lo", 2, 16'(acc_log[2][201]), 16'h011F);
    check("frame8 pixel hi", 2, 16'(acc_log[2][227]), 16'h01F8);

`ifdef LCD_PATTERN_CHECKER_EN
    x16_hi = 9'h100;
    x16_lo = 9'h100;
`else
    x16_hi = 9'h1F8;
    x16_lo = 9'h100;
`endif
    check("x0 hi", 3, 16'(acc_log[3][11]), 16'h01F8);
    check("x0 lo", 3, 16'(acc_log[3][12]), 16'h0100);
    check("x15 hi", 3, 16'(acc_log[3][41]), 16'h01F8);
    check("x15 lo", 3, 16'(acc_log[3][42]), 16'h0100);
    check("x16 hi", 3, 16'(acc_log[3][43]), 16'(x16_hi));
    check("x16 lo", 3, 16'(acc_log[3][44]), 16'(x16_lo));
    check("x31 hi", 3, 16'(acc_log[3][73]), 16'(x16_hi));
    check("x31 lo", 3, 16'(acc_log[3][74]), 16'(x16_lo));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
